// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: result-source, funct3, access-size and FSM state constants shared by the M/W stage
package mem_wb_stage_pkg;
  localparam logic [1:0] RES_ALU = 2'b00, RES_LOAD = 2'b01, RES_PC4 = 2'b10;
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RESP = 2'd2;
  function automatic logic [1:0] acc_size(input logic [2:0] f3, input logic st);
    return (f3 == F3_B || (!st && f3 == F3_BU)) ? SZ_B : (f3 == F3_H || (!st && f3 == F3_HU)) ? SZ_H : SZ_W;
  endfunction
endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: picks the addressed lane of a read word and sign/zero extends it (rdata, lane, funct3 -> data)
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [31:0] sh;
  logic [1:0] sz;
  always_comb begin
    sh = rdata >> {lane, 3'b000};
    sz = acc_size(funct3, 1'b0);
    data = sz == SZ_B ? {{24{sh[7] & ~funct3[2]}}, sh[7:0]} : sz == SZ_H ? {{16{sh[15] & ~funct3[2]}}, sh[15:0]} : rdata;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: M-stage data-memory handshake FSM plus registered W bundle (M controls in, dmem req/rsp, StallM/MisalignM, RegWriteW/RdW/ResultW out)
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        Funct3M,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [DATA_W-1:0] PCPlus4M,
  input  logic [4:0]        RdM,
  output logic              dmem_req_valid,
  output logic              dmem_req_we,
  output logic [DATA_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  output logic [3:0]        dmem_req_be,
  input  logic              dmem_req_ready,
  input  logic              dmem_rsp_valid,
  input  logic [DATA_W-1:0] dmem_rsp_rdata,
  output logic              StallM,
  output logic              MisalignM,
  output logic              RegWriteW,
  output logic [4:0]        RdW,
  output logic [DATA_W-1:0] ResultW
);
  logic [1:0] state, state_n, sz;
  logic is_store, is_load, access, misalign, store_acc, rsp_done, wb_en;
  logic [DATA_W-1:0] load_data;
  load_align u_align (.rdata(dmem_rsp_rdata), .lane(ALUResultM[1:0]), .funct3(Funct3M), .data(load_data));
  always_comb begin
    is_store = MemWriteM;
    is_load = ResultSrcM == RES_LOAD && !MemWriteM;
    access = is_store || is_load;
    sz = acc_size(Funct3M, MemWriteM);
    misalign = access && (sz == SZ_H ? ALUResultM[0] : sz == SZ_W ? |ALUResultM[1:0] : 1'b0);
    MisalignM = misalign;
    dmem_req_valid = access && !misalign && state != ST_RESP;
    dmem_req_we = is_store;
    dmem_req_addr = {ALUResultM[DATA_W-1:2], 2'b00};
    dmem_req_be = sz == SZ_B ? 4'b0001 << ALUResultM[1:0] : sz == SZ_H ? (ALUResultM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    dmem_req_wdata = sz == SZ_B ? {4{WriteDataM[7:0]}} : sz == SZ_H ? {2{WriteDataM[15:0]}} : WriteDataM;
    store_acc = dmem_req_valid && dmem_req_ready && is_store;
    rsp_done = state == ST_RESP && dmem_rsp_valid;
    StallM = access && !misalign && !store_acc && !rsp_done;
    wb_en = !access || rsp_done;
    state_n = state == ST_RESP ? (dmem_rsp_valid ? ST_IDLE : ST_RESP) :
              !dmem_req_valid ? ST_IDLE : !dmem_req_ready ? ST_REQ : is_load ? ST_RESP : ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      RegWriteW <= 1'b0;
      RdW <= 5'd0;
      ResultW <= '0;
    end else begin
      state <= state_n;
      RegWriteW <= wb_en && RegWriteM;
      RdW <= wb_en ? RdM : 5'd0;
      ResultW <= rsp_done ? load_data : ResultSrcM == RES_PC4 ? PCPlus4M : ALUResultM;
    end
  end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: DATA_W, default 32, datapath and address width; only 32 is supported.
REQ-002 Port: clk  in  1  sole clock, all state on posedge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: RegWriteM, MemWriteM  in  1 each  M-stage control from execute/memory register.
REQ-005 Port: ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4; 11 reserved, treated as ALU.
REQ-006 Port: Funct3M  in  3  RV32I load/store size code.
REQ-007 Port: ALUResultM, WriteDataM, PCPlus4M  in  32 each  address or ALU result, store data, link value.
REQ-008 Port: RdM  in  5  destination register.
REQ-009 Port: dmem_req_valid, dmem_req_we  out  1 each  data-memory request valid, write enable.
REQ-010 Port: dmem_req_addr, dmem_req_wdata  out  32 each  word-aligned address (bits 1:0 = 0), lane-replicated write data.
REQ-011 Port: dmem_req_be  out  4  byte enables.
REQ-012 Port: dmem_req_ready, dmem_rsp_valid  in  1 each  request accepted, read data valid.
REQ-013 Port: dmem_rsp_rdata  in  32  read data.
REQ-014 Port: StallM  out  1  freezes M stage and all earlier stages.
REQ-015 Port: MisalignM  out  1  misaligned access flag, one cycle.
REQ-016 Port: RegWriteW, RdW, ResultW  out  1/5/32  registered writeback bundle.

Function
REQ-017 FSM states: IDLE, REQ, RESP. IDLE: no access outstanding. REQ: request offered, not yet accepted. RESP: load accepted, awaiting data.
REQ-018 Access = load (ResultSrcM=01) or store (MemWriteM=1); both set counts as store.
REQ-019 In IDLE/REQ with an aligned access: dmem_req_valid=1 combinationally; IDLE->REQ if !dmem_req_ready.
REQ-020 Request fields stay stable while dmem_req_valid && !dmem_req_ready.
REQ-021 Store accepted: instruction retires that cycle, no W write, FSM->IDLE; a zero-wait store never stalls.
REQ-022 Load accepted: FSM->RESP; at most one outstanding request.
REQ-023 In RESP: dmem_rsp_valid=1 -> extract lane ALUResultM[1:0], sign/zero extend per Funct3M, register into ResultW with RegWriteW=RegWriteM, FSM->IDLE.
REQ-024 StallM = access pending && !(store accepted this cycle) && !(RESP && dmem_rsp_valid).
REQ-025 While StallM=1, W gets a bubble: RegWriteW<=0, RdW<=0.
REQ-026 Non-access instruction: ResultW<=ALUResultM or PCPlus4M, RdW<=RdM, RegWriteW<=RegWriteM on next edge, latency 1.
REQ-027 Byte enables: SB 1<<addr[1:0], SH 0011/1100, SW 1111; SB replicates byte x4, SH replicates half x2.
REQ-028 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no request, MisalignM=1, W bubble, no stall, state unchanged.
REQ-029 dmem_rsp_valid outside RESP is ignored.
REQ-030 Funct3 codes outside the RV32I load/store set are treated as word.

Reset
REQ-031 rst asynchronously forces state IDLE and RegWriteW, RdW, ResultW to 0.
REQ-032 During and after reset: dmem_req_valid=0, StallM=0, MisalignM=0 until new M-stage input.
REQ-033 Reset mid-access abandons it; a later stray dmem_rsp_valid is dropped per REQ-029.

Structure
REQ-034 Shared package holds: result_src encoding, Funct3 load/store constants, FSM state enum.
REQ-035 Sub-module load_align (combinational): lane select plus sign/zero extension; everything else in mem_wb_stage.

Verification
REQ-036 ADD, ALUResultM=0x1234, RdM=5, RegWriteM=1 -> next edge ResultW=0x1234, RdW=5, RegWriteW=1, StallM never 1.
REQ-037 SB, addr 0x103, data 0xAB, ready=1 -> be=1000, wdata=0xABABABAB, addr=0x100, StallM=0.
REQ-038 LB, addr 0x102, ready=1, rsp after 3 cycles with 0x00800000 -> StallM high 3 cycles, 3 W bubbles, then ResultW=0xFFFFFF80; LBU gives 0x00000080.
REQ-039 SW, ready low 2 cycles -> req fields stable, StallM=1 two cycles, retires on third.
REQ-040 LW, addr 0x101 -> no request, MisalignM=1 one cycle, RegWriteW=0.
REQ-041 rst asserted in RESP, then rsp_valid=1 -> all outputs 0, FSM IDLE, response ignored.
